fsm_mssv_tx: RTL and testbench

- Moore-style frame generator that drives the 3-bit symbol stream consumed by the team's sequence detectors.
- On a start request it emits the fixed preamble 000, 110, 000, 110 followed by a latched tail symbol, optionally repeating the frame with idle gaps.
- It also reports the done code the detector must produce for that tail.
- Sits upstream of the detector as its stimulus/transmit end.

---
 rtl/fsm_mssv_tx.sv | 125 ++++++++++++
 tb/tb_fsm_mssv_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_mssv_tx.sv
// Frame generator: preamble 000,110,000,110 + latched tail, REPEAT frames separated by GAP idle cycles.
// Latency: first symbol one cycle after start is accepted in IDLE; all outputs decoded from registers.
// Backpressure: stall=1 freezes the FSM and the symbol in P0..TAIL; ignored in IDLE, GAP and FIN.
module fsm_mssv_tx #(
  parameter int unsigned REPEAT   = 1,
  parameter int unsigned GAP      = 2,
  parameter logic [2:0]  IDLE_SYM = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] tail_sym,
  input  logic       stall,
  output logic [2:0] mssv_tx,
  output logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] exp_done,
  output logic [3:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_TAIL = 3'd5,
    S_GAP  = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  localparam logic [3:0] REPEAT_C = 4'(REPEAT);
  localparam logic [3:0] GAP_C    = 4'(GAP);

  state_t     state_q;
  state_t     state_nxt;
  logic [2:0] tail_q;
  logic [1:0] exp_done_q;
  logic [3:0] frame_cnt_q;
  logic [3:0] gap_cnt_q;
  logic [3:0] frame_inc;
  logic       accept;
  logic       tail_leave;

  // Frame count after the current tail completes, saturating at 15
  assign frame_inc  = (frame_cnt_q == 4'd15) ? 4'd15 : frame_cnt_q + 4'd1;
  assign accept     = (state_q == S_IDLE) && start;
  assign tail_leave = (state_q == S_TAIL) && !stall;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode; stall only holds the symbol-carrying states
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (start) state_nxt = S_P0;
      S_P0:   if (!stall) state_nxt = S_P1;
      S_P1:   if (!stall) state_nxt = S_P2;
      S_P2:   if (!stall) state_nxt = S_P3;
      S_P3:   if (!stall) state_nxt = S_TAIL;
      S_TAIL: begin
        if (!stall) begin
          if (frame_inc < REPEAT_C) begin
            state_nxt = (GAP_C != 4'd0) ? S_GAP : S_P0;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_GAP:  if (gap_cnt_q <= 4'd1) state_nxt = S_P0;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tail latch, expected detector code, frame and gap counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_q      <= 3'd0;
      exp_done_q  <= 2'b00;
      frame_cnt_q <= 4'd0;
      gap_cnt_q   <= 4'd0;
    end else begin
      if (accept) begin
        tail_q      <= tail_sym;
        exp_done_q  <= {1'b1, ~tail_sym[0]};
        frame_cnt_q <= 4'd0;
      end
      if (tail_leave) begin
        frame_cnt_q <= frame_inc;
        gap_cnt_q   <= GAP_C;
      end else if (state_q == S_GAP && gap_cnt_q != 4'd0) begin
        gap_cnt_q <= gap_cnt_q - 4'd1;
      end
    end
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    mssv_tx  = IDLE_SYM;
    tx_valid = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
    case (state_q)
      S_P0:   begin mssv_tx = 3'b000; tx_valid = 1'b1; end
      S_P1:   begin mssv_tx = 3'b110; tx_valid = 1'b1; end
      S_P2:   begin mssv_tx = 3'b000; tx_valid = 1'b1; end
      S_P3:   begin mssv_tx = 3'b110; tx_valid = 1'b1; end
      S_TAIL: begin mssv_tx = tail_q; tx_valid = 1'b1; end
      default: begin mssv_tx = IDLE_SYM; tx_valid = 1'b0; end
    endcase
  end

  assign exp_done  = exp_done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fsm_mssv_tx.sv
module tb_fsm_mssv_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [2:0] tail_sym;
  logic       start_a, start_b, start_c;

  logic [2:0] tx_a, tx_b, tx_c;
  logic       vld_a, vld_b, vld_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [1:0] exp_a, exp_b, exp_c;
  logic [3:0] fcnt_a, fcnt_b, fcnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Default parameters: REPEAT=1, GAP=2
  fsm_mssv_tx u_a (
    .clk(clk), .rst(rst), .start(start_a), .tail_sym(tail_sym), .stall(stall),
    .mssv_tx(tx_a), .tx_valid(vld_a), .busy(busy_a), .done(done_a),
    .exp_done(exp_a), .frame_cnt(fcnt_a)
  );

  fsm_mssv_tx #(.REPEAT(3), .GAP(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .tail_sym(tail_sym), .stall(stall),
    .mssv_tx(tx_b), .tx_valid(vld_b), .busy(busy_b), .done(done_b),
    .exp_done(exp_b), .frame_cnt(fcnt_b)
  );

  fsm_mssv_tx #(.REPEAT(2), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .tail_sym(tail_sym), .stall(stall),
    .mssv_tx(tx_c), .tx_valid(vld_c), .busy(busy_c), .done(done_c),
    .exp_done(exp_c), .frame_cnt(fcnt_c)
  );

  // Expected {mssv_tx, tx_valid, busy, done}: code 0..4 frame position, 5 FIN, 6 IDLE, 7 GAP
  function automatic logic [5:0] exp_vec(input int code, input logic [2:0] t);
    case (code)
      0, 2:    return {3'b000, 1'b1, 1'b1, 1'b0};
      1, 3:    return {3'b110, 1'b1, 1'b1, 1'b0};
      4:       return {t,      1'b1, 1'b1, 1'b0};
      5:       return {3'b111, 1'b0, 1'b1, 1'b1};
      7:       return {3'b111, 1'b0, 1'b1, 1'b0};
      default: return {3'b111, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    stall = 1'b0; tail_sym = 3'b000;
    #2;
    checks++;
    if ({tx_a, vld_a, busy_a, done_a} !== exp_vec(6, 3'b000)) begin
      errors++; $display("FAIL reset_outputs got %b expected %b", {tx_a, vld_a, busy_a, done_a}, exp_vec(6, 3'b000));
    end
    checks++;
    if ({exp_a, fcnt_a} !== 6'd0) begin
      errors++; $display("FAIL reset_exp_cnt got %b expected %b", {exp_a, fcnt_a}, 6'd0);
    end
    checks++;
    if ({tx_b, tx_c, busy_b, busy_c} !== {3'b111, 3'b111, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_other got %b expected %b", {tx_b, tx_c, busy_b, busy_c}, {3'b111, 3'b111, 1'b0, 1'b0});
    end
    // Start a frame, then reset while in P2
    rst = 1'b1;
    step();
    tail_sym = 3'b011; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    checks++;
    if ({tx_a, vld_a} !== {3'b000, 1'b1}) begin
      errors++; $display("FAIL reset_pre_p2 got %b expected %b", {tx_a, vld_a}, {3'b000, 1'b1});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tx_a, vld_a, busy_a, done_a} !== exp_vec(6, 3'b000)) begin
      errors++; $display("FAIL reset_midframe got %b expected %b", {tx_a, vld_a, busy_a, done_a}, exp_vec(6, 3'b000));
    end
    checks++;
    if ({exp_a, fcnt_a} !== 6'd0) begin
      errors++; $display("FAIL reset_midframe_regs got %b expected %b", {exp_a, fcnt_a}, 6'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({tx_a, vld_a, busy_a, done_a} !== exp_vec(6, 3'b000)) begin
        errors++; $display("FAIL reset_stay_idle k=%0d got %b expected %b", k, {tx_a, vld_a, busy_a, done_a}, exp_vec(6, 3'b000));
      end
    end
  endtask

  task automatic test_frame(input logic [2:0] t, input logic [1:0] exp_code);
    tail_sym = t; start_a = 1'b1;
    step();
    start_a = 1'b0;
    tail_sym = ~t;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({tx_a, vld_a, busy_a, done_a} !== exp_vec(k, t)) begin
        errors++; $display("FAIL frame tail=%b k=%0d got %b expected %b", t, k, {tx_a, vld_a, busy_a, done_a}, exp_vec(k, t));
      end
      if (k >= 5) begin
        checks++;
        if ({exp_a, fcnt_a} !== {exp_code, 4'd1}) begin
          errors++; $display("FAIL frame_code tail=%b k=%0d got %b expected %b", t, k, {exp_a, fcnt_a}, {exp_code, 4'd1});
        end
      end
      if (k < 6) step();
    end
  endtask

  task automatic test_stall();
    int seq [9] = '{0, 1, 1, 1, 2, 3, 4, 5, 6};
    tail_sym = 3'b101; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if ({tx_a, vld_a, busy_a, done_a} !== exp_vec(seq[k], 3'b101)) begin
        errors++; $display("FAIL stall k=%0d got %b expected %b", k, {tx_a, vld_a, busy_a, done_a}, exp_vec(seq[k], 3'b101));
      end
      if (k == 1) stall = 1'b1;
      if (k == 3) stall = 1'b0;
      if (k < 8) step();
    end
    checks++;
    if (exp_a !== 2'b10) begin
      errors++; $display("FAIL stall_exp got %b expected %b", exp_a, 2'b10);
    end
  endtask

  task automatic test_start_stall();
    int seq [8] = '{0, 0, 1, 2, 3, 4, 5, 6};
    tail_sym = 3'b000; start_a = 1'b1; stall = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({tx_a, vld_a, busy_a, done_a} !== exp_vec(seq[k], 3'b000)) begin
        errors++; $display("FAIL start_stall k=%0d got %b expected %b", k, {tx_a, vld_a, busy_a, done_a}, exp_vec(seq[k], 3'b000));
      end
      if (k == 1) stall = 1'b0;
      if (k < 7) step();
    end
    checks++;
    if (exp_a !== 2'b11) begin
      errors++; $display("FAIL start_stall_exp got %b expected %b", exp_a, 2'b11);
    end
  endtask

  task automatic test_repeat_gap();
    int code;
    logic [3:0] fc;
    tail_sym = 3'b010; start_b = 1'b1;
    step();
    tail_sym = 3'b111;
    for (int k = 0; k < 21; k++) begin
      if (k == 19)      code = 5;
      else if (k == 20) code = 6;
      else              code = ((k % 7) < 5) ? (k % 7) : 7;
      fc = 4'((k + 2) / 7);
      checks++;
      if ({tx_b, vld_b, busy_b, done_b} !== exp_vec(code, 3'b010)) begin
        errors++; $display("FAIL repeat_gap k=%0d got %b expected %b", k, {tx_b, vld_b, busy_b, done_b}, exp_vec(code, 3'b010));
      end
      checks++;
      if (fcnt_b !== fc) begin
        errors++; $display("FAIL repeat_cnt k=%0d got %0d expected %0d", k, fcnt_b, fc);
      end
      if (k == 19) start_b = 1'b0;
      if (k < 20) step();
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({busy_b, vld_b, fcnt_b, exp_b} !== {1'b0, 1'b0, 4'd3, 2'b11}) begin
        errors++; $display("FAIL repeat_no_rerun k=%0d got %b expected %b", k, {busy_b, vld_b, fcnt_b, exp_b}, {1'b0, 1'b0, 4'd3, 2'b11});
      end
    end
  endtask

  task automatic test_back_to_back();
    int code;
    logic [3:0] fc;
    tail_sym = 3'b100; start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int k = 0; k < 12; k++) begin
      code = (k < 10) ? (k % 5) : ((k == 10) ? 5 : 6);
      fc = (k < 5) ? 4'd0 : ((k < 10) ? 4'd1 : 4'd2);
      checks++;
      if ({tx_c, vld_c, busy_c, done_c} !== exp_vec(code, 3'b100)) begin
        errors++; $display("FAIL back_to_back k=%0d got %b expected %b", k, {tx_c, vld_c, busy_c, done_c}, exp_vec(code, 3'b100));
      end
      checks++;
      if (fcnt_c !== fc) begin
        errors++; $display("FAIL back_to_back_cnt k=%0d got %0d expected %0d", k, fcnt_c, fc);
      end
      if (k < 11) step();
    end
    checks++;
    if (exp_c !== 2'b11) begin
      errors++; $display("FAIL back_to_back_exp got %b expected %b", exp_c, 2'b11);
    end
  endtask

  initial begin
    test_reset();
    test_frame(3'b110, 2'b11);
    test_frame(3'b111, 2'b10);
    test_stall();
    test_start_stall();
    test_repeat_gap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
